param_reservation_station: RTL
==============================

Name: param_reservation_station

Overview:
- Parametrised successor to the 5-entry reservation station: configurable depth, data/tag widths and number of result-broadcast (forward) channels.
- Accepts a new operation whenever any slot is free, not only when the station is empty.
- Captures forwarded operands at insertion time, and holds the selected issue entry stable under downstream back-pressure (valid/ready handshake).
- Sits between rename/dispatch and one functional unit; wakes up on CDB broadcasts from all units.

Parameters:
- DEPTH, 8, number of entries (2..32)
- DATA_W, 16, operand width
- ROB_W, 6, ROB tag width
- OP_W, 4, opcode width
- NUM_FWD, 4, number of broadcast channels

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; clears all entries
- flush  in  1  synchronous squash of all entries
- inValid  in  1  dispatch offers an operation
- inAccept  out  1  operation written this cycle
- inOp  in  OP_W  opcode
- inRob  in  ROB_W  destination ROB tag
- inWaitA, inWaitB  in  1 each  operand not yet available
- inTagA, inTagB  in  ROB_W each  producer tags
- inValA, inValB  in  DATA_W each  operand values, used when the wait bit is 0
- fwdValid  in  NUM_FWD  per-channel broadcast valid
- fwdTag  in  NUM_FWD*ROB_W  channel k occupies bits [k*ROB_W +: ROB_W]
- fwdData  in  NUM_FWD*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- outValid  out  1  an issue-ready entry is presented
- outReady  in  1  functional unit takes the presented entry
- outOp, outRob, outA, outB  out  OP_W/ROB_W/DATA_W/DATA_W  presented operation
- count  out  clog2(DEPTH+1)  occupied entries
- full  out  1  count == DEPTH

Behaviour:
- Reset (priority over everything):
  - all entry valid bits = 0, lock = 0.
  - outValid = 0, count = 0, full = 0, inAccept = 0.
- Flush (when reset is low): same clearing as reset.
  - inAccept is forced to 0 and no issue handshake completes that cycle.
- Accept:
  - inAccept = inValid & !full & !flush & !reset, combinational.
  - full is computed from registered state only, so a same-cycle issue does not free a slot for insertion.
  - Insertion goes to the lowest-index free slot.
- Insert-time capture:
  - If inWaitA=1 and any fwdValid[k] has fwdTag[k]==inTagA in the accept cycle, the entry stores fwdData[k] with waitA=0.
  - Same rule for B.
- Wakeup:
  - Each cycle, every valid entry with waitX=1 and a matching broadcast clears waitX and latches the data.
  - If several channels match, the lowest k wins.
  - Both operands may wake in the same cycle.
- Ready condition: an entry is ready when valid & !waitA & !waitB, evaluated on registered state. Wakeup-to-issue latency is 1 cycle; there is no same-cycle bypass to the output.
- Selection:
  - Picks the highest-priority ready entry (priority per the optional feature).
  - outValid = lock | any ready.
  - Outputs are driven combinationally from the selected or locked entry.
- Handshake:
  - outValid & outReady → the entry's valid bit is cleared at the edge and lock = 0.
  - outValid & !outReady → lock = 1 and the selected index is stored in lockIdx. The same entry is presented, with all fields unchanged, until accepted or flushed, even if an older entry becomes ready.
- Simultaneous insert and issue: both take effect. count = count + 1 - 1 = count, and the freed slot is reusable from the next cycle.
- count tracks occupancy exactly; it never exceeds DEPTH and never underflows.
- Broadcasts on a cycle with flush or reset are ignored.

Optional Feature:
- Macro: RS_AGE_ORDER_EN.
- Defined:
  - Each entry keeps an age of width clog2(DEPTH).
  - On insert, the new entry gets age 0 and every valid entry increments its age.
  - On issue, every entry older than the issued one decrements its age.
  - Insert and issue in the same cycle apply both rules. Ages stay unique in 0..count-1.
  - Selection picks the ready entry with the maximum age (oldest first).
- Undefined: no age state; selection picks the lowest-index ready entry.

Test Plan:
- Reset, then dispatch op=3 rob=5 A=0x0011 B=0x0022 with no waits → outValid=1 on the next cycle, outA=0x0011, outB=0x0022, count=1. With outReady=1 → count=0 the cycle after.
- Dispatch rob=7 with waitA, tagA=9. Broadcast tag 9 data 0xBEEF on channel 2 two cycles later → outValid rises 1 cycle after the broadcast with outA=0xBEEF.
- Dispatch with waitB tagB=4 while channel 0 broadcasts tag 4 data 0x1234 in the same cycle → entry is ready next cycle with outB=0x1234.
- Fill DEPTH=8 entries, all waiting → full=1, inAccept=0 on a 9th inValid. One issue frees a slot → inAccept=1 on the following cycle.
- Hold outReady=0 with entry rob=2 presented, then make an older entry ready → outRob stays 2 until outReady=1. With RS_AGE_ORDER_EN, the older entry issues next.
- Fill 5 entries, then assert flush for one cycle together with inValid and a matching broadcast → count=0, outValid=0, inAccept=0. Assert reset mid-stream → the same result.

Source files
------------

// File: rtl/param_reservation_station.sv
// Parametrised reservation station: dispatch into any free slot, CDB wakeup, and a held issue slot under back-pressure.
// Optional RS_AGE_ORDER_EN selects the oldest ready entry; without it the lowest-index ready entry is picked.
module param_reservation_station #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 16,
  parameter int ROB_W   = 6,
  parameter int OP_W    = 4,
  parameter int NUM_FWD = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        inValid,
  output logic                        inAccept,
  input  logic [OP_W-1:0]             inOp,
  input  logic [ROB_W-1:0]            inRob,
  input  logic                        inWaitA,
  input  logic                        inWaitB,
  input  logic [ROB_W-1:0]            inTagA,
  input  logic [ROB_W-1:0]            inTagB,
  input  logic [DATA_W-1:0]           inValA,
  input  logic [DATA_W-1:0]           inValB,
  input  logic [NUM_FWD-1:0]          fwdValid,
  input  logic [NUM_FWD*ROB_W-1:0]    fwdTag,
  input  logic [NUM_FWD*DATA_W-1:0]   fwdData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [OP_W-1:0]             outOp,
  output logic [ROB_W-1:0]            outRob,
  output logic [DATA_W-1:0]           outA,
  output logic [DATA_W-1:0]           outB,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        full
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  wait_a_q, wait_a_d, wait_b_q, wait_b_d;
  logic [ROB_W-1:0]  tag_a_q [DEPTH];
  logic [ROB_W-1:0]  tag_a_d [DEPTH];
  logic [ROB_W-1:0]  tag_b_q [DEPTH];
  logic [ROB_W-1:0]  tag_b_d [DEPTH];
  logic [DATA_W-1:0] val_a_q [DEPTH];
  logic [DATA_W-1:0] val_a_d [DEPTH];
  logic [DATA_W-1:0] val_b_q [DEPTH];
  logic [DATA_W-1:0] val_b_d [DEPTH];
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [OP_W-1:0]   op_d    [DEPTH];
  logic [ROB_W-1:0]  rob_q   [DEPTH];
  logic [ROB_W-1:0]  rob_d   [DEPTH];
  logic              lock_q, lock_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  ready;
  logic [IDX_W-1:0]  sel_idx, free_idx, pres_idx;
  logic              squash, issue_fire;

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0]  age_q [DEPTH];
  logic [IDX_W-1:0]  age_d [DEPTH];
  logic [IDX_W-1:0]  sel_age;
  logic              sel_found;
`endif

  // Readiness, free-slot search and issue selection all look at registered state only.
  always_comb begin
    ready    = valid_q & ~wait_a_q & ~wait_b_q;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
`ifdef RS_AGE_ORDER_EN
    sel_idx   = '0;
    sel_age   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_found || age_q[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_age   = age_q[i];
        sel_idx   = IDX_W'(i);
      end
    end
`else
    sel_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ready[i]) sel_idx = IDX_W'(i);
    end
`endif
  end

  assign pres_idx   = lock_q ? lock_idx_q : sel_idx;
  assign squash     = reset | flush;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign count      = count_q;
  assign inAccept   = inValid & ~full & ~squash;
  assign outValid   = lock_q | (|ready);
  assign issue_fire = outValid & outReady & ~squash;
  assign outOp      = op_q[pres_idx];
  assign outRob     = rob_q[pres_idx];
  assign outA       = val_a_q[pres_idx];
  assign outB       = val_b_q[pres_idx];

  always_comb begin
    valid_d    = valid_q;
    wait_a_d   = wait_a_q;
    wait_b_d   = wait_b_q;
    tag_a_d    = tag_a_q;
    tag_b_d    = tag_b_q;
    val_a_d    = val_a_q;
    val_b_d    = val_b_q;
    op_d       = op_q;
    rob_d      = rob_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    count_d    = count_q + CNT_W'(inAccept) - CNT_W'(issue_fire);

    // Descending channel scan so the lowest matching channel is the last write.
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = NUM_FWD-1; k >= 0; k--) begin
        if (valid_q[i] && wait_a_q[i] && fwdValid[k] && fwdTag[k*ROB_W +: ROB_W] == tag_a_q[i]) begin
          wait_a_d[i] = 1'b0;
          val_a_d[i]  = fwdData[k*DATA_W +: DATA_W];
        end
        if (valid_q[i] && wait_b_q[i] && fwdValid[k] && fwdTag[k*ROB_W +: ROB_W] == tag_b_q[i]) begin
          wait_b_d[i] = 1'b0;
          val_b_d[i]  = fwdData[k*DATA_W +: DATA_W];
        end
      end
    end

    if (issue_fire) begin
      valid_d[pres_idx] = 1'b0;
      lock_d            = 1'b0;
    end else if (outValid) begin
      lock_d     = 1'b1;
      lock_idx_d = pres_idx;
    end

    if (inAccept) begin
      valid_d[free_idx]  = 1'b1;
      op_d[free_idx]     = inOp;
      rob_d[free_idx]    = inRob;
      tag_a_d[free_idx]  = inTagA;
      tag_b_d[free_idx]  = inTagB;
      wait_a_d[free_idx] = inWaitA;
      wait_b_d[free_idx] = inWaitB;
      val_a_d[free_idx]  = inValA;
      val_b_d[free_idx]  = inValB;
      for (int k = NUM_FWD-1; k >= 0; k--) begin
        if (inWaitA && fwdValid[k] && fwdTag[k*ROB_W +: ROB_W] == inTagA) begin
          wait_a_d[free_idx] = 1'b0;
          val_a_d[free_idx]  = fwdData[k*DATA_W +: DATA_W];
        end
        if (inWaitB && fwdValid[k] && fwdTag[k*ROB_W +: ROB_W] == inTagB) begin
          wait_b_d[free_idx] = 1'b0;
          val_b_d[free_idx]  = fwdData[k*DATA_W +: DATA_W];
        end
      end
    end

    if (squash) begin
      valid_d = '0;
      lock_d  = 1'b0;
      count_d = '0;
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Ages of live entries stay a permutation of 0..count-1; stale ages of free slots are never read.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        age_d[i] = age_q[i] + IDX_W'(inAccept)
                   - IDX_W'(issue_fire && (age_q[i] > age_q[pres_idx]));
      end
    end
    if (inAccept) age_d[free_idx] = '0;
  end

  always_ff @(posedge clk) begin
    age_q <= age_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
    end
  end

  // Payload is only meaningful while the matching valid bit is set, so it carries no reset.
  always_ff @(posedge clk) begin
    wait_a_q <= wait_a_d;
    wait_b_q <= wait_b_d;
    tag_a_q  <= tag_a_d;
    tag_b_q  <= tag_b_d;
    val_a_q  <= val_a_d;
    val_b_q  <= val_b_d;
    op_q     <= op_d;
    rob_q    <= rob_d;
  end

endmodule
